mac_stream_checker: RTL

Synthesizable in-line scoreboard for the part1 MAC. It taps the MAC's input stream (a, b, valid_in, MAC synchronous reset) and its output stream (f, valid_out), runs a cycle-accurate reference model of the MAC, and compares the two every cycle. It sits beside part1_mac in FPGA/emulation builds and in long random benches, and exposes sticky error status plus counters.

---
 rtl/mac_chk_pkg.sv | 14 +
 rtl/mac_ref_model.sv | 76 +++++++
 rtl/mac_stream_checker.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mac_chk_pkg.sv
// rtl/mac_chk_pkg.sv - shared types and default widths for the MAC stream checker
package mac_chk_pkg;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_VALID = 2'd1,
        ERR_DATA  = 2'd2
    } err_kind_t;

    localparam int DEF_IN_WIDTH  = 10;
    localparam int DEF_OUT_WIDTH = 20;
    localparam int DEF_CNT_WIDTH = 16;

endpackage

// File: rtl/mac_ref_model.sv
// rtl/mac_ref_model.sv - cycle-accurate two-stage reference model of the part1 MAC
//
// clk, reset_n          : checker clock, async active-low checker reset
// mac_reset             : MAC's own synchronous active-high reset
// a, b, valid_in        : tapped MAC input stream
// exp_f, exp_valid      : model accumulator and output valid
module mac_ref_model
    import mac_chk_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        mac_reset,
    input  logic signed [IN_WIDTH-1:0]  a,
    input  logic signed [IN_WIDTH-1:0]  b,
    input  logic                        valid_in,
    output logic [OUT_WIDTH-1:0]        exp_f,
    output logic                        exp_valid
);

    localparam int PW = 2 * IN_WIDTH;

    logic signed [IN_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic                       v_q, v_d;
    logic [OUT_WIDTH-1:0]       acc_q, acc_d;
    logic                       ev_q, ev_d;
    logic signed [PW-1:0]        prod;
    logic signed [OUT_WIDTH-1:0] prod_ext;

    // Full-precision signed product, sign-extended; accumulation wraps.
    always_comb begin
        prod     = PW'(a_q) * PW'(b_q);
        prod_ext = OUT_WIDTH'(prod);
    end

    always_comb begin
        a_d   = a;
        b_d   = b;
        v_d   = valid_in;
        acc_d = acc_q;
        ev_d  = v_q;
        if (v_q) begin
            acc_d = acc_q + prod_ext;
        end
        // MAC reset wins over a simultaneous valid operand.
        if (mac_reset) begin
            a_d   = '0;
            b_d   = '0;
            v_d   = 1'b0;
            acc_d = '0;
            ev_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            v_q   <= 1'b0;
            acc_q <= '0;
            ev_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            v_q   <= v_d;
            acc_q <= acc_d;
            ev_q  <= ev_d;
        end
    end

    assign exp_f     = acc_q;
    assign exp_valid = ev_q;

endmodule

// File: rtl/mac_stream_checker.sv
// rtl/mac_stream_checker.sv - in-line scoreboard comparing the MAC against its reference model
//
// clk, reset_n                  : shared clock, async active-low checker reset
// mac_reset                     : MAC synchronous reset (resets model only)
// a, b, valid_in                : tapped MAC input stream
// f, valid_out                  : tapped MAC output stream
// check_en                      : gates counting/flagging of comparisons
// exp_f, exp_valid              : model outputs
// err_flag, err_count           : sticky error and saturating mismatch count
// check_count                   : saturating count of compared valid cycles
// first_err_cycle/first_err_kind: cycle index and kind of the first mismatch
module mac_stream_checker
    import mac_chk_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        mac_reset,
    input  logic signed [IN_WIDTH-1:0]  a,
    input  logic signed [IN_WIDTH-1:0]  b,
    input  logic                        valid_in,
    input  logic [OUT_WIDTH-1:0]        f,
    input  logic                        valid_out,
    input  logic                        check_en,
    output logic [OUT_WIDTH-1:0]        exp_f,
    output logic                        exp_valid,
    output logic                        err_flag,
    output logic [CNT_WIDTH-1:0]        err_count,
    output logic [CNT_WIDTH-1:0]        check_count,
    output logic [CNT_WIDTH-1:0]        first_err_cycle,
    output err_kind_t                   first_err_kind
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    mac_ref_model #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_model (
        .clk       (clk),
        .reset_n   (reset_n),
        .mac_reset (mac_reset),
        .a         (a),
        .b         (b),
        .valid_in  (valid_in),
        .exp_f     (exp_f),
        .exp_valid (exp_valid)
    );

    err_kind_t            kind_now;
    logic                 counting;
    logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH-1:0] chk_cnt_q, chk_cnt_d;
    logic [CNT_WIDTH-1:0] first_cyc_q, first_cyc_d;
    logic                 err_flag_q, err_flag_d;
    err_kind_t            first_kind_q, first_kind_d;

    always_comb begin
        kind_now = ERR_NONE;
        if (exp_valid != valid_out) begin
            kind_now = ERR_VALID;
        end else if (exp_valid && (f != exp_f)) begin
            kind_now = ERR_DATA;
        end
    end

    // While the MAC is held in reset its outputs are not meaningful.
    assign counting = check_en && !mac_reset;

    always_comb begin
        cycle_d      = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + CNT_ONE;
        err_cnt_d    = err_cnt_q;
        chk_cnt_d    = chk_cnt_q;
        first_cyc_d  = first_cyc_q;
        err_flag_d   = err_flag_q;
        first_kind_d = first_kind_q;
        if (counting) begin
            if (exp_valid && (chk_cnt_q != CNT_MAX)) begin
                chk_cnt_d = chk_cnt_q + CNT_ONE;
            end
            if (kind_now != ERR_NONE) begin
                if (err_cnt_q != CNT_MAX) begin
                    err_cnt_d = err_cnt_q + CNT_ONE;
                end
                err_flag_d = 1'b1;
                if (!err_flag_q) begin
                    first_cyc_d  = cycle_q;
                    first_kind_d = kind_now;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q      <= '0;
            err_cnt_q    <= '0;
            chk_cnt_q    <= '0;
            first_cyc_q  <= '0;
            err_flag_q   <= 1'b0;
            first_kind_q <= ERR_NONE;
        end else begin
            cycle_q      <= cycle_d;
            err_cnt_q    <= err_cnt_d;
            chk_cnt_q    <= chk_cnt_d;
            first_cyc_q  <= first_cyc_d;
            err_flag_q   <= err_flag_d;
            first_kind_q <= first_kind_d;
        end
    end

    assign err_flag        = err_flag_q;
    assign err_count       = err_cnt_q;
    assign check_count     = chk_cnt_q;
    assign first_err_cycle = first_cyc_q;
    assign first_err_kind  = first_kind_q;

endmodule
